ucsbece154b_mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing one burst-read memory port between NR_REQ refill requesters
//  (I-fetch FIFO refill, D-cache refill, ...). Grants one requester at a time and issues its address.

---
 rtl/ucsbece154b_arb_pkg.sv | 38 +++
 rtl/ucsbece154b_mem_arbiter_if.sv | 30 +++
 rtl/ucsbece154b_rr_picker.sv | 14 +
 rtl/ucsbece154b_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucsbece154b_arb_pkg.sv
// Shared types and the round-robin pick function for the memory-port arbiters.
package ucsbece154b_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int unsigned PERF_CNT_W = 32;
    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    // One-hot of the first set request bit searching upward from ptr+1, wrapping at n.
    function automatic logic [RR_MAX_REQ-1:0] rr_next(
        input int unsigned           n,
        input int unsigned           ptr,
        input logic [RR_MAX_REQ-1:0] req
    );
        logic [RR_MAX_REQ-1:0] gnt;
        logic                  found;
        int unsigned           idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
            if (i <= n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[RR_IDX_W'(idx)]) begin
                    gnt[RR_IDX_W'(idx)] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ucsbece154b_mem_arbiter_if.sv
// Requester-side and memory-side signals of the burst-read arbiter.
// master: the arbiter's view; slave: the requesters/memory environment's view.
interface ucsbece154b_mem_arbiter_if #(
    parameter int unsigned NR_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NR_REQ-1:0]                 req_i;
    logic [NR_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NR_REQ-1:0]                 gnt_o;
    logic [NR_REQ-1:0]                 rvalid_o;
    logic [DATA_WIDTH-1:0]             rdata_o;
    logic                              rlast_o;
    logic                              mem_req_o;
    logic [ADDR_WIDTH-1:0]             mem_addr_o;
    logic                              mem_ready_i;
    logic                              mem_rvalid_i;
    logic [DATA_WIDTH-1:0]             mem_rdata_i;

    modport master (
        input  req_i, addr_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, rlast_o, mem_req_o, mem_addr_o
    );

    modport slave (
        output req_i, addr_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, rlast_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/ucsbece154b_rr_picker.sv
// Stateless round-robin picker: request vector plus last-served pointer to one-hot grant.
module ucsbece154b_rr_picker #(
    parameter  int unsigned NR_REQ = 2,
    localparam int unsigned PTR_W  = $clog2(NR_REQ)
) (
    input  logic [NR_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NR_REQ-1:0] gnt_o
);
    import ucsbece154b_arb_pkg::*;

    assign gnt_o = NR_REQ'(rr_next(NR_REQ, 32'(ptr_i), RR_MAX_REQ'(req_i)));

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Round-robin arbiter sharing one burst-read memory port between NR_REQ refill requesters.
// Optional UCSBECE154B_ARB_PERF_EN adds per-requester burst and wait-cycle counters.
module ucsbece154b_mem_arbiter
    import ucsbece154b_arb_pkg::*;
#(
    parameter int unsigned NR_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    ucsbece154b_mem_arbiter_if.master        bus
`ifdef UCSBECE154B_ARB_PERF_EN
    ,
    output logic [NR_REQ-1:0][PERF_CNT_W-1:0] perf_bursts_o,
    output logic [PERF_CNT_W-1:0]             perf_wait_o
`endif
);
    localparam int unsigned    PTR_W     = $clog2(NR_REQ);
    localparam int unsigned    CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_e                  state_q, state_d;
    logic [NR_REQ-1:0]       gnt_q, gnt_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;

    logic [NR_REQ-1:0]       pick_c;
    logic [ADDR_WIDTH-1:0]   pick_addr_c;
    logic [PTR_W-1:0]        gnt_idx_c;
    logic                    beat_c;
    logic                    last_c;

    ucsbece154b_rr_picker #(
        .NR_REQ (NR_REQ)
    ) u_picker (
        .req_i  (bus.req_i),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_c)
    );

    // Address of the picked requester and index of the currently granted one.
    always_comb begin
        pick_addr_c = '0;
        gnt_idx_c   = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (pick_c[i]) pick_addr_c = pick_addr_c | bus.addr_i[i];
            if (gnt_q[i])  gnt_idx_c   = PTR_W'(i);
        end
    end

    // Beats only count while a burst is being collected; strays elsewhere are dropped.
    assign beat_c = (state_q == DATA) && bus.mem_rvalid_i;
    assign last_c = beat_c && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    state_d    = ADDR;
                    gnt_d      = pick_c;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pick_addr_c;
                end
            end
            ADDR: begin
                if (bus.mem_ready_i) begin
                    state_d   = DATA;
                    mem_req_d = 1'b0;
                end
            end
            DATA: begin
                if (beat_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_c) begin
                        cnt_d   = '0;
                        gnt_d   = '0;
                        ptr_d   = gnt_idx_c;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                mem_req_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // Pointer resets to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            ptr_q      <= PTR_W'(NR_REQ - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.rvalid_o   = beat_c ? gnt_q : '0;
    assign bus.rdata_o    = beat_c ? bus.mem_rdata_i : '0;
    assign bus.rlast_o    = last_c;

`ifdef UCSBECE154B_ARB_PERF_EN
    logic [NR_REQ-1:0][PERF_CNT_W-1:0] perf_bursts_q, perf_bursts_d;
    logic [PERF_CNT_W-1:0]             perf_wait_q, perf_wait_d;

    // Saturating completed-burst and blocked-request counters.
    always_comb begin
        perf_bursts_d = perf_bursts_q;
        perf_wait_d   = perf_wait_q;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (last_c && gnt_q[i] && (perf_bursts_q[i] != '1)) begin
                perf_bursts_d[i] = perf_bursts_q[i] + PERF_CNT_W'(1);
            end
        end
        if ((|bus.req_i) && (state_q != IDLE) && (perf_wait_q != '1)) begin
            perf_wait_d = perf_wait_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_bursts_q <= '0;
            perf_wait_q   <= '0;
        end else begin
            perf_bursts_q <= perf_bursts_d;
            perf_wait_q   <= perf_wait_d;
        end
    end

    assign perf_bursts_o = perf_bursts_q;
    assign perf_wait_o   = perf_wait_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Scoreboard bench for ucsbece154b_mem_arbiter with four requesters and four-beat bursts.
module tb_ucsbece154b_mem_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ucsbece154b_mem_arbiter_if #(.NR_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ucsbece154b_mem_arbiter #(
        .NR_REQ     (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [NR-1:0] gnt;
        logic [AW-1:0] addr;
        int            gap;
    } grant_t;

    typedef struct {
        logic [NR-1:0] rv;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    grant_t gq[$];
    beat_t  bq[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_grant(input logic [NR-1:0] g, input logic [AW-1:0] a, input int gap);
        grant_t e;
        e.gnt = g; e.addr = a; e.gap = gap;
        gq.push_back(e);
    endtask

    task automatic push_burst(input logic [NR-1:0] g, input logic [DW-1:0] base);
        beat_t e;
        for (int b = 0; b < int'(BL); b++) begin
            e.rv = g; e.data = base + DW'(b); e.last = (b == int'(BL) - 1);
            bq.push_back(e);
        end
    endtask

    // Monitor: pops expectations whenever a grant rises or a beat is presented.
    logic [NR-1:0] prev_gnt = '0;
    int            gap_cnt  = -1;
    always @(negedge clk) begin
        grant_t ge;
        beat_t  be;
        if (rst) begin
            prev_gnt = '0;
            gap_cnt  = -1;
        end else begin
            if (bus.gnt_o != '0 && prev_gnt == '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 64'(bus.gnt_o), 64'(0));
                end else begin
                    ge = gq.pop_front();
                    chk("grant", 64'(bus.gnt_o), 64'(ge.gnt));
                    chk("grant_addr", 64'(bus.mem_addr_o), 64'(ge.addr));
                    chk("grant_mem_req", 64'(bus.mem_req_o), 64'(1));
                    if (ge.gap >= 0) chk("grant_gap", 64'(gap_cnt), 64'(ge.gap));
                end
            end
            if (bus.gnt_o == '0) begin
                if (prev_gnt != '0) gap_cnt = 1;
                else if (gap_cnt >= 0) gap_cnt++;
            end
            if (bus.rvalid_o != '0 || bus.rlast_o) begin
                if (bq.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.rvalid_o), 64'(0));
                end else begin
                    be = bq.pop_front();
                    chk("beat_rvalid", 64'(bus.rvalid_o), 64'(be.rv));
                    chk("beat_rdata", 64'(bus.rdata_o), 64'(be.data));
                    chk("beat_rlast", 64'(bus.rlast_o), 64'(be.last));
                end
            end
            prev_gnt = bus.gnt_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(output bit ok);
        int t;
        t = 0;
        while (bus.mem_req_o !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        ok = (bus.mem_req_o === 1'b1);
        if (!ok) chk("mem_req_timeout", 64'(bus.mem_req_o), 64'(1));
    endtask

    // Memory model for one burst; optionally injects strays, stalls, request drops and address churn.
    task automatic mem_burst(input logic [DW-1:0] base, input int ready_dly, input int stall,
                             input logic [NR-1:0] drop_mask, input bit stray, input bit scramble,
                             input logic [AW-1:0] exp_addr);
        bit ok;
        logic [NR-1:0][AW-1:0] saved;
        wait_mem_req(ok);
        if (!ok) return;
        saved = bus.addr_i;
        if (scramble) bus.addr_i = {NR{32'hFFFF_0BAD}};
        for (int i = 0; i < ready_dly; i++) begin
            if (stray) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = 32'h0000_0BAD;
            end
            tick();
            chk("mem_req_hold", 64'(bus.mem_req_o), 64'(1));
            chk("mem_addr_hold", 64'(bus.mem_addr_o), 64'(exp_addr));
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_ready_i  = 1'b1;
        tick();
        bus.mem_ready_i  = 1'b0;
        chk("mem_req_drop", 64'(bus.mem_req_o), 64'(0));
        for (int b = 0; b < int'(BL); b++) begin
            if (b > 0) repeat (stall) tick();
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = base + DW'(b);
            tick();
            bus.mem_rvalid_i = 1'b0;
            if (b == 0) bus.req_i = bus.req_i & ~drop_mask;
        end
        bus.addr_i = saved;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, 64'(bus.gnt_o), 64'(0));
        chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'(0));
        chk({tag, "_rdata"}, 64'(bus.rdata_o), 64'(0));
        chk({tag, "_rlast"}, 64'(bus.rlast_o), 64'(0));
        chk({tag, "_mem_req"}, 64'(bus.mem_req_o), 64'(0));
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.req_i        = '0;
        bus.addr_i[0]    = 32'h0000_0100;
        bus.addr_i[1]    = 32'h0000_0200;
        bus.addr_i[2]    = 32'h0000_0300;
        bus.addr_i[3]    = 32'h0000_0400;
        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;

        // Reset values, then an asynchronous reset landing in the middle of ADDR.
        #1 rst = 1'b1;
        #1 chk_quiet("por");
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_gnt", 64'(bus.gnt_o), 64'(0));
        chk("idle_no_mem_req", 64'(bus.mem_req_o), 64'(0));
        bus.req_i = 4'b0001;
        wait_mem_req(ok);
        #2 rst = 1'b1;
        #1 chk_quiet("async_rst");
        bus.req_i = '0;
        tick();
        rst = 1'b0;
        tick();

        // Single requester, memory accepts after two cycles.
        push_grant(4'b0001, 32'h100, -1);
        push_burst(4'b0001, 32'hA);
        bus.req_i = 4'b0001;
        mem_burst(32'hA, 2, 0, '0, 1'b0, 1'b0, 32'h100);
        bus.req_i = '0;
        repeat (2) tick();

        // Contention from a fresh pointer: 0,1,0,1 with one idle cycle between grants.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        push_grant(4'b0001, 32'h100, -1); push_burst(4'b0001, 32'h1000);
        push_grant(4'b0010, 32'h200, 1);  push_burst(4'b0010, 32'h2000);
        push_grant(4'b0001, 32'h100, 1);  push_burst(4'b0001, 32'h3000);
        push_grant(4'b0010, 32'h200, 1);  push_burst(4'b0010, 32'h4000);
        bus.req_i = 4'b0011;
        mem_burst(32'h1000, 1, 0, '0, 1'b0, 1'b0, 32'h100);
        mem_burst(32'h2000, 1, 0, '0, 1'b0, 1'b0, 32'h200);
        mem_burst(32'h3000, 1, 0, '0, 1'b0, 1'b0, 32'h100);
        mem_burst(32'h4000, 1, 0, '0, 1'b0, 1'b0, 32'h200);
        bus.req_i = '0;
        repeat (2) tick();

        // Requester 3 served, then 1010 -> 1 before 3.
        push_grant(4'b1000, 32'h400, -1); push_burst(4'b1000, 32'h5000);
        bus.req_i = 4'b1000;
        mem_burst(32'h5000, 0, 0, '0, 1'b0, 1'b0, 32'h400);
        bus.req_i = '0;
        repeat (2) tick();
        push_grant(4'b0010, 32'h200, -1); push_burst(4'b0010, 32'h6000);
        push_grant(4'b1000, 32'h400, 1);  push_burst(4'b1000, 32'h7000);
        bus.req_i = 4'b1010;
        mem_burst(32'h6000, 0, 0, '0, 1'b0, 1'b0, 32'h200);
        mem_burst(32'h7000, 0, 0, '0, 1'b0, 1'b0, 32'h400);
        bus.req_i = '0;
        repeat (2) tick();

        // Request dropped after first beat, stalls, strays in ADDR and IDLE, address churn.
        push_grant(4'b0001, 32'h100, -1); push_burst(4'b0001, 32'h8000);
        bus.req_i = 4'b0001;
        mem_burst(32'h8000, 2, 3, 4'b0001, 1'b1, 1'b1, 32'h100);
        chk("req_dropped", 64'(bus.req_i), 64'(0));
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hDEAD;
            tick();
            chk("stray_rvalid", 64'(bus.rvalid_o), 64'(0));
            chk("stray_rdata", 64'(bus.rdata_o), 64'(0));
            chk("stray_gnt", 64'(bus.gnt_o), 64'(0));
        end
        bus.mem_rvalid_i = 1'b0;
        tick();

        // Reset during beat 2 of 4; pointer returns so requester 0 wins 0011.
        push_grant(4'b0001, 32'h100, -1);
        begin
            beat_t e;
            e.rv = 4'b0001; e.data = 32'h9000; e.last = 1'b0;
            bq.push_back(e);
        end
        bus.req_i = 4'b0001;
        wait_mem_req(ok);
        bus.mem_ready_i = 1'b1;
        tick();
        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h9000;
        tick();
        bus.mem_rdata_i  = 32'h9001;
        #2 rst = 1'b1;
        #1 chk_quiet("mid_burst_rst");
        bus.req_i = '0;
        tick();
        bus.mem_rvalid_i = 1'b0;
        rst = 1'b0;
        tick();
        push_grant(4'b0001, 32'h100, -1); push_burst(4'b0001, 32'hA000);
        bus.req_i = 4'b0011;
        mem_burst(32'hA000, 1, 0, '0, 1'b0, 1'b0, 32'h100);
        bus.req_i = '0;
        repeat (3) tick();

        chk("grant_queue_drained", 64'(gq.size()), 64'(0));
        chk("beat_queue_drained", 64'(bq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
